stage_sequencer: RTL and testbench

- Owns the one-hot CPU stage register and computes its next value each cycle.
- Stages are FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Advances on per-stage completion conditions, runs the fetch and memory request/ack handshakes, skips MEMORY for non-memory ops and redirects to FETCH on trap.
- Its stage vector drives every stage-gated enable in the core.

---
 rtl/stage_sequencer.sv | 83 ++++++++
 tb/tb_stage_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// One-hot CPU stage register (FETCH..WRITEBACK) with fetch/memory handshakes, trap redirect and corruption recovery.
// Optional retired-instruction counter (instret/instret_clr) enabled by defining STAGE_SEQ_RETIRE_COUNTER_EN.
module stage_sequencer #(
  parameter int unsigned                NUM_STAGES  = 5,
  parameter logic [NUM_STAGES-1:0]      RESET_STAGE = 5'b00001
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  run_en,
  input  logic                  fetch_ack,
  input  logic                  exec_done,
  input  logic                  is_mem_op,
  input  logic                  mem_ack,
  input  logic                  trap,
  output logic [NUM_STAGES-1:0] stage,
  output logic [NUM_STAGES-1:0] stage_next,
  output logic                  fetch_req,
  output logic                  mem_req,
  output logic                  retire,
  output logic                  stage_error
`ifdef STAGE_SEQ_RETIRE_COUNTER_EN
  ,
  input  logic                  instret_clr,
  output logic [31:0]           instret
`endif
);

  typedef enum logic [NUM_STAGES-1:0] {
    FETCH     = 5'b00001,
    DECODE    = 5'b00010,
    EXECUTE   = 5'b00100,
    MEMORY    = 5'b01000,
    WRITEBACK = 5'b10000
  } stage_e;

  logic [NUM_STAGES-1:0] r_stage;
  logic [NUM_STAGES-1:0] w_stage_next;
  logic                  w_onehot;

  assign w_onehot = $onehot(r_stage);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_stage <= RESET_STAGE;
    else       r_stage <= w_stage_next;
  end

  // Recovery outranks trap, which outranks normal advance; acks are only seen in their own stage.
  always_comb begin
    w_stage_next = r_stage;
    if (!w_onehot || trap) begin
      w_stage_next = FETCH;
    end else begin
      case (r_stage)
        FETCH:     if (run_en && fetch_ack) w_stage_next = DECODE;
        DECODE:    w_stage_next = EXECUTE;
        EXECUTE:   if (exec_done) w_stage_next = is_mem_op ? MEMORY : WRITEBACK;
        MEMORY:    if (mem_ack) w_stage_next = WRITEBACK;
        WRITEBACK: w_stage_next = FETCH;
        default:   w_stage_next = FETCH;
      endcase
    end
  end

  assign stage       = r_stage;
  assign stage_next  = w_stage_next;
  assign stage_error = ~w_onehot;
  assign fetch_req   = w_onehot && (r_stage == FETCH) && run_en;
  assign mem_req     = w_onehot && (r_stage == MEMORY);
  assign retire      = w_onehot && (r_stage == WRITEBACK) && !trap;

`ifdef STAGE_SEQ_RETIRE_COUNTER_EN
  logic [31:0] r_instret;

  always_ff @(posedge clk or posedge clear) begin
    if (clear)            r_instret <= '0;
    else if (instret_clr) r_instret <= '0;
    else if (retire)      r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized, self-checking bench for stage_sequencer against a stage-index reference model plus directed literal cases.
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       run_en = 1'b0, fetch_ack = 1'b0, exec_done = 1'b0, is_mem_op = 1'b0;
  logic       mem_ack = 1'b0, trap = 1'b0;
  logic [4:0] stage, stage_next;
  logic       fetch_req, mem_req, retire, stage_error;
`ifdef STAGE_SEQ_RETIRE_COUNTER_EN
  logic        instret_clr = 1'b0;
  logic [31:0] instret;
  logic [31:0] m_instret = '0;
`endif

  int errors = 0;
  int checks = 0;
  int m_idx  = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  stage_sequencer #(.NUM_STAGES(5), .RESET_STAGE(5'b00001)) dut (
    .clk(clk), .clear(clear), .run_en(run_en), .fetch_ack(fetch_ack),
    .exec_done(exec_done), .is_mem_op(is_mem_op), .mem_ack(mem_ack), .trap(trap),
    .stage(stage), .stage_next(stage_next), .fetch_req(fetch_req), .mem_req(mem_req),
    .retire(retire), .stage_error(stage_error)
`ifdef STAGE_SEQ_RETIRE_COUNTER_EN
    , .instret_clr(instret_clr), .instret(instret)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Stage indices 0..4 = FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
  function automatic int model_next(int idx, bit re, bit fa, bit ed, bit im, bit ma, bit tr);
    if (tr) return 0;
    case (idx)
      0:       return (re && fa) ? 1 : 0;
      1:       return 2;
      2:       return !ed ? 2 : (im ? 3 : 4);
      3:       return ma ? 4 : 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      m_idx = 0;
`ifdef STAGE_SEQ_RETIRE_COUNTER_EN
      m_instret = '0;
`endif
    end else begin
`ifdef STAGE_SEQ_RETIRE_COUNTER_EN
      if (instret_clr) m_instret = '0;
      else if (m_idx == 4 && !trap) m_instret = m_instret + 32'd1;
`endif
      m_idx = model_next(m_idx, run_en, fetch_ack, exec_done, is_mem_op, mem_ack, trap);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stage", 32'(stage), 32'(1) << m_idx);
      check("stage_next", 32'(stage_next),
            32'(1) << model_next(m_idx, run_en, fetch_ack, exec_done, is_mem_op, mem_ack, trap));
      check("fetch_req", 32'(fetch_req), 32'(m_idx == 0 && run_en));
      check("mem_req", 32'(mem_req), 32'(m_idx == 3));
      check("retire", 32'(retire), 32'(m_idx == 4 && !trap));
      check("stage_error", 32'(stage_error), 32'(0));
`ifdef STAGE_SEQ_RETIRE_COUNTER_EN
      check("instret", instret, m_instret);
`endif
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifdef STAGE_SEQ_RETIRE_COUNTER_EN
  task automatic run_alu(input bit clr_in_wb);
    for (int c = 0; c < 4; c++) begin
      fetch_ack = (c == 0); exec_done = 1'b1; is_mem_op = 1'b0;
      instret_clr = clr_in_wb && (c == 3);
      next_cycle();
    end
    fetch_ack = 1'b0; instret_clr = 1'b0;
  endtask
`endif

  logic [4:0] seq [9];
  int         cnt;

  initial begin
    // Reset and idle
    @(negedge clk);
    check("rst_stage", 32'(stage), 32'h01);
    check("rst_fetch_req", 32'(fetch_req), 32'(0));
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_retire", 32'(retire), 32'(0));
    check("rst_stage_error", 32'(stage_error), 32'(0));
    next_cycle();
    clear = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_stage", 32'(stage), 32'h01);
      check("idle_fetch_req", 32'(fetch_req), 32'(0));
    end
    next_cycle();
    run_en = 1'b1;
    #1;
    check("run_en_fetch_req", 32'(fetch_req), 32'(1));

    // ALU instruction: 4 cycles, one retire
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      fetch_ack = (c == 0); exec_done = 1'b1; is_mem_op = 1'b0;
      @(negedge clk);
      seq[c] = stage;
      if (retire) cnt++;
      next_cycle();
    end
    check("alu_seq0", 32'(seq[0]), 32'h01);
    check("alu_seq1", 32'(seq[1]), 32'h02);
    check("alu_seq2", 32'(seq[2]), 32'h04);
    check("alu_seq3", 32'(seq[3]), 32'h10);
    check("alu_seq4", 32'(seq[4]), 32'h01);
    check("alu_retires", 32'(cnt), 32'(1));

    // Load with 3 wait states
    cnt = 0;
    for (int c = 0; c < 9; c++) begin
      fetch_ack = (c == 0); exec_done = 1'b1; is_mem_op = 1'b1; mem_ack = (c == 6);
      @(negedge clk);
      seq[c] = stage;
      if (mem_req) cnt++;
      next_cycle();
    end
    mem_ack = 1'b0;
    check("ld_seq2", 32'(seq[2]), 32'h04);
    check("ld_seq3", 32'(seq[3]), 32'h08);
    check("ld_seq6", 32'(seq[6]), 32'h08);
    check("ld_seq7", 32'(seq[7]), 32'h10);
    check("ld_seq8", 32'(seq[8]), 32'h01);
    check("ld_mem_req_cycles", 32'(cnt), 32'(4));

    // Trap together with mem_ack in MEMORY
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      fetch_ack = (c == 0); exec_done = 1'b1; is_mem_op = 1'b1;
      trap = (c == 3); mem_ack = (c == 3);
      @(negedge clk);
      if (retire) cnt++;
      if (c == 3) begin
        check("trap_stage", 32'(stage), 32'h08);
        check("trap_stage_next", 32'(stage_next), 32'h01);
      end
      if (c == 4) begin
        check("trap_after_stage", 32'(stage), 32'h01);
        check("trap_after_mem_req", 32'(mem_req), 32'(0));
      end
      next_cycle();
    end
    trap = 1'b0; mem_ack = 1'b0; fetch_ack = 1'b0;
    check("trap_no_retire", 32'(cnt), 32'(0));

    // Corruption recovery (idle in FETCH, run_en high but no ack)
    chk_en = 1'b0;
    force dut.r_stage = 5'b00110;
    #1;
    check("corrupt_stage_error", 32'(stage_error), 32'(1));
    check("corrupt_stage_next", 32'(stage_next), 32'h01);
    check("corrupt_fetch_req", 32'(fetch_req), 32'(0));
    check("corrupt_mem_req", 32'(mem_req), 32'(0));
    check("corrupt_retire", 32'(retire), 32'(0));
    release dut.r_stage;
    next_cycle();
    check("recover_stage", 32'(stage), 32'h01);
    check("recover_stage_error", 32'(stage_error), 32'(0));
    chk_en = 1'b1;

`ifdef STAGE_SEQ_RETIRE_COUNTER_EN
    instret_clr = 1'b1;
    next_cycle();
    instret_clr = 1'b0;
    for (int k = 0; k < 3; k++) run_alu(1'b0);
    check("instret_three", instret, 32'd3);
    force dut.r_instret = 32'hFFFF_FFFF;
    m_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    run_alu(1'b0);
    check("instret_wrap", instret, 32'd0);
    run_alu(1'b0);
    run_alu(1'b1);
    check("instret_clr_wins", instret, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      clear     = ($urandom_range(0, 99) == 0);
      run_en    = ($urandom_range(0, 9) != 0);
      fetch_ack = $urandom_range(0, 1) == 1;
      exec_done = $urandom_range(0, 1) == 1;
      is_mem_op = $urandom_range(0, 1) == 1;
      mem_ack   = ($urandom_range(0, 4) < 2);
      trap      = ($urandom_range(0, 19) == 0);
`ifdef STAGE_SEQ_RETIRE_COUNTER_EN
      instret_clr = ($urandom_range(0, 49) == 0);
`endif
      next_cycle();
    end
    clear = 1'b0; trap = 1'b0;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
